// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the ALU datapath sequencer.
// Function codes match the 8-function ALU select inputs.
package alu_pkg;

  localparam int FUNC_W = 3;
  localparam int DATA_W = 4;

  localparam logic [2:0] FN_INC    = 3'b000;
  localparam logic [2:0] FN_ADD_RC = 3'b001;
  localparam logic [2:0] FN_ADD    = 3'b010;
  localparam logic [2:0] FN_ORXOR  = 3'b011;
  localparam logic [2:0] FN_REDOR  = 3'b100;
  localparam logic [2:0] FN_SHL    = 3'b101;
  localparam logic [2:0] FN_SHR    = 3'b110;
  localparam logic [2:0] FN_MUL    = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT_STEP,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/prog_store.sv
// Program entry array: async clear, synchronous write, combinational read.
// Entries are packed as {func, operand}.
module prog_store #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int W      = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Issues a stored (function, operand) program to the ALU/accumulator,
// free-running or one op per step pulse. All outputs are registered.
module alu_sequencer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int FUNC_W = alu_pkg::FUNC_W,
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [FUNC_W-1:0] wr_func,
  input  logic [DATA_W-1:0] wr_operand,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  output logic [FUNC_W-1:0] alu_func,
  output logic [DATA_W-1:0] alu_a,
  output logic              acc_load,
  output logic              acc_clear,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  import alu_pkg::*;

  localparam int EW = FUNC_W + DATA_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  seq_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              smode_q, smode_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              load_q, load_d;
  logic              clear_q, clear_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [EW-1:0] rd;
  logic          wr_ok;
  logic          last;
  logic          show;

  assign wr_ok = wr_en && (state_q == S_IDLE || state_q == S_DONE);
  assign last  = ({1'b0, pc_q} == len_q - 1'b1);

  // Read address follows the next pc so operands register with the state.
  prog_store #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .W     (EW)
  ) u_store (
    .clock(clock),
    .reset(reset),
    .we   (wr_ok),
    .waddr(wr_addr),
    .wdata({wr_func, wr_operand}),
    .raddr(pc_d),
    .rdata(rd)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    smode_d = smode_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (prog_len != '0) begin
            len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
            smode_d = step_mode;
            pc_d    = '0;
            state_d = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR: state_d = S_ISSUE;
      S_ISSUE: begin
        if (last) begin
          pc_d    = '0;
          state_d = S_DONE;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = smode_q ? S_WAIT_STEP : S_ISSUE;
        end
      end
      S_WAIT_STEP: begin
        if (step) begin
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        pc_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    show    = (state_d == S_ISSUE) || (state_d == S_WAIT_STEP);
    func_d  = show ? rd[EW-1:DATA_W] : '0;
    a_d     = show ? rd[DATA_W-1:0] : '0;
    load_d  = (state_d == S_ISSUE);
    clear_d = (state_d == S_CLEAR);
    busy_d  = show || clear_d;
    done_d  = (state_d == S_DONE);
    err_d   = wr_en && !wr_ok;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      smode_q <= 1'b0;
      func_q  <= '0;
      a_q     <= '0;
      load_q  <= 1'b0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      smode_q <= smode_d;
      func_q  <= func_d;
      a_q     <= a_d;
      load_q  <= load_d;
      clear_q <= clear_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign alu_func  = func_q;
  assign alu_a     = a_q;
  assign acc_load  = load_q;
  assign acc_clear = clear_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_err    = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small ALU/accumulator model.
// Cycle k is the interval after clock edge k-1.
module tb_alu_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [2:0] wr_func = '0;
  logic [3:0] wr_operand = '0;
  logic [3:0] prog_len = '0;
  logic       start = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic [2:0] alu_func;
  logic [3:0] alu_a;
  logic       acc_load;
  logic       acc_clear;
  logic [2:0] pc;
  logic       busy;
  logic       done;
  logic       wr_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] acc_m;
  int         load_cnt;
  int         clr_cnt;

  alu_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_func   (wr_func),
    .wr_operand(wr_operand),
    .prog_len  (prog_len),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .alu_func  (alu_func),
    .alu_a     (alu_a),
    .acc_load  (acc_load),
    .acc_clear (acc_clear),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .wr_err    (wr_err)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [7:0] alu_f(input logic [2:0] f,
                                       input logic [3:0] a,
                                       input logic [7:0] acc);
    case (f)
      3'b000:  return {4'b0, a} + 8'd1;
      3'b010:  return acc + {4'b0, a};
      3'b111:  return acc * {4'b0, a};
      default: return acc;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_m    <= '0;
      load_cnt <= 0;
      clr_cnt  <= 0;
    end else begin
      if (acc_clear) acc_m <= '0;
      else if (acc_load) acc_m <= alu_f(alu_func, alu_a, acc_m);
      if (acc_load) load_cnt <= load_cnt + 1;
      if (acc_clear) clr_cnt <= clr_cnt + 1;
    end
  end

  typedef struct {
    string      nm;
    logic       clr;
    logic       ld;
    logic       bsy;
    logic       dn;
    logic [2:0] pcv;
    logic [2:0] fn;
    logic [3:0] a;
    logic [7:0] acc;
    logic       acc_chk;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] ad, input logic [2:0] f,
                    input logic [3:0] op);
    wr_en = 1'b1;
    wr_addr = ad;
    wr_func = f;
    wr_operand = op;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] len, input logic sm);
    prog_len = len;
    step_mode = sm;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, ".busy"}, {7'b0, busy}, 8'h0);
    chk({nm, ".load"}, {7'b0, acc_load}, 8'h0);
    chk({nm, ".clear"}, {7'b0, acc_clear}, 8'h0);
    chk({nm, ".done"}, {7'b0, done}, 8'h0);
    chk({nm, ".func"}, {5'b0, alu_func}, 8'h0);
    chk({nm, ".a"}, {4'b0, alu_a}, 8'h0);
    chk({nm, ".pc"}, {5'b0, pc}, 8'h0);
  endtask

  initial begin
    int base_ld;
    int base_clr;
    int idx;
    logic seen_done;

    tbl[0] = '{"c1_clear", 1, 0, 1, 0, 0, 0, 4'h0, 8'h00, 0};
    tbl[1] = '{"c2_op0",   0, 1, 1, 0, 0, 0, 4'h5, 8'h00, 1};
    tbl[2] = '{"c3_op1",   0, 1, 1, 0, 1, 2, 4'h3, 8'h06, 1};
    tbl[3] = '{"c4_op2",   0, 1, 1, 0, 2, 7, 4'h2, 8'h09, 1};
    tbl[4] = '{"c5_done",  0, 0, 0, 1, 0, 0, 4'h0, 8'h12, 1};
    tbl[5] = '{"c6_idle",  0, 0, 0, 0, 0, 0, 4'h0, 8'h12, 1};

    #12;
    reset = 1'b0;
    tick();
    chk_idle_outs("reset");
    chk("reset.wr_err", {7'b0, wr_err}, 8'h0);

    wr(3'd0, 3'b000, 4'd5);
    wr(3'd1, 3'b010, 4'd3);
    wr(3'd2, 3'b111, 4'd2);

    // Free-run table
    start_run(4'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk({tbl[i].nm, ".clear"}, {7'b0, acc_clear}, {7'b0, tbl[i].clr});
      chk({tbl[i].nm, ".load"}, {7'b0, acc_load}, {7'b0, tbl[i].ld});
      chk({tbl[i].nm, ".busy"}, {7'b0, busy}, {7'b0, tbl[i].bsy});
      chk({tbl[i].nm, ".done"}, {7'b0, done}, {7'b0, tbl[i].dn});
      chk({tbl[i].nm, ".pc"}, {5'b0, pc}, {5'b0, tbl[i].pcv});
      chk({tbl[i].nm, ".func"}, {5'b0, alu_func}, {5'b0, tbl[i].fn});
      chk({tbl[i].nm, ".a"}, {4'b0, alu_a}, {4'b0, tbl[i].a});
      if (tbl[i].acc_chk) chk({tbl[i].nm, ".acc"}, acc_m, tbl[i].acc);
      tick();
    end

    // Single-step run
    base_ld = load_cnt;
    start_run(4'd3, 1'b1);
    chk("st.c1.clear", {7'b0, acc_clear}, 8'h1);
    tick();
    chk("st.c2.load", {7'b0, acc_load}, 8'h1);
    chk("st.c2.a", {4'b0, alu_a}, 8'h5);
    tick();
    chk("st.c3.load", {7'b0, acc_load}, 8'h0);
    chk("st.c3.busy", {7'b0, busy}, 8'h1);
    chk("st.c3.pc", {5'b0, pc}, 8'h1);
    chk("st.c3.func", {5'b0, alu_func}, 8'h2);
    tick();
    chk("st.c4.pc", {5'b0, pc}, 8'h1);
    chk("st.c4.load", {7'b0, acc_load}, 8'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("st.c5.load", {7'b0, acc_load}, 8'h1);
    chk("st.c5.pc", {5'b0, pc}, 8'h1);
    tick();
    chk("st.c6.pc", {5'b0, pc}, 8'h2);
    chk("st.c6.load", {7'b0, acc_load}, 8'h0);
    chk("st.c6.a", {4'b0, alu_a}, 8'h2);
    tick();
    chk("st.c7.load", {7'b0, acc_load}, 8'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("st.c8.load", {7'b0, acc_load}, 8'h1);
    chk("st.c8.func", {5'b0, alu_func}, 8'h7);
    tick();
    chk("st.c9.done", {7'b0, done}, 8'h1);
    chk("st.c9.busy", {7'b0, busy}, 8'h0);
    chk("st.c9.acc", acc_m, 8'h12);
    chk("st.loads", 8'(load_cnt - base_ld), 8'd3);
    tick();

    // Zero-length run
    base_ld = load_cnt;
    base_clr = clr_cnt;
    start_run(4'd0, 1'b0);
    chk("z.c1.done", {7'b0, done}, 8'h1);
    chk("z.c1.busy", {7'b0, busy}, 8'h0);
    chk("z.c1.clear", {7'b0, acc_clear}, 8'h0);
    tick();
    chk("z.c2.done", {7'b0, done}, 8'h0);
    chk("z.c2.busy", {7'b0, busy}, 8'h0);
    chk("z.loads", 8'(load_cnt - base_ld), 8'd0);
    chk("z.clears", 8'(clr_cnt - base_clr), 8'd0);

    // Rejected write during a run
    start_run(4'd3, 1'b0);
    tick();
    tick();
    wr_en = 1'b1;
    wr_addr = 3'd0;
    wr_func = 3'b101;
    wr_operand = 4'hf;
    chk("we.c3.err", {7'b0, wr_err}, 8'h0);
    tick();
    wr_en = 1'b0;
    chk("we.c4.err", {7'b0, wr_err}, 8'h1);
    tick();
    chk("we.c5.err", {7'b0, wr_err}, 8'h0);
    chk("we.c5.done", {7'b0, done}, 8'h1);
    tick();
    start_run(4'd3, 1'b0);
    tick();
    chk("we.rerun.func", {5'b0, alu_func}, 8'h0);
    chk("we.rerun.a", {4'b0, alu_a}, 8'h5);
    for (int i = 0; i < 4; i++) tick();

    // Length clamp
    base_ld = load_cnt;
    idx = 0;
    seen_done = 1'b0;
    start_run(4'd12, 1'b0);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (acc_load) begin
        chk("clamp.pc", {5'b0, pc}, 8'(idx));
        idx++;
      end
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    chk("clamp.done_seen", {7'b0, seen_done}, 8'h1);
    chk("clamp.loads", 8'(load_cnt - base_ld), 8'd8);
    tick();

    // Reset mid-run
    start_run(4'd3, 1'b0);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk_idle_outs("rst_mid");
    #2 reset = 1'b0;
    tick();
    start_run(4'd3, 1'b0);
    chk("pr.c1.clear", {7'b0, acc_clear}, 8'h1);
    tick();
    chk("pr.c2.load", {7'b0, acc_load}, 8'h1);
    chk("pr.c2.a", {4'b0, alu_a}, 8'h0);
    tick();
    chk("pr.c3.pc", {5'b0, pc}, 8'h1);
    chk("pr.c3.func", {5'b0, alu_func}, 8'h0);
    chk("pr.c3.a", {4'b0, alu_a}, 8'h0);
    tick();
    tick();
    chk("pr.c5.done", {7'b0, done}, 8'h1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
